// File: rtl/dmem_responder.sv
// Store-side responder for the core's data bus: word RAM with a registered debug read port,
// plus an MMIO page (LED, UART TX queue + serial transmitter, overflow flag). Optional parity: DMEM_TX_PARITY_EN.
module dmem_responder #(
    parameter int unsigned RAM_WORDS    = 256,
    parameter logic [31:0] MMIO_BASE    = 32'h0000_1000,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_data,
    input  logic        mem_we,
    input  logic [31:0] dbg_addr,
    output logic [31:0] dbg_rdata,
    output logic [7:0]  led,
    output logic        uart_tx,
    output logic        tx_busy,
    output logic        ovf
);

    localparam int unsigned AW = $clog2(RAM_WORDS);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [PW:0]   FIFO_FULL = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef DMEM_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } tx_state_t;

    logic [31:0]   ram  [RAM_WORDS];
    logic [7:0]    fifo [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count, count_next;

    tx_state_t     state;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
`ifdef DMEM_TX_PARITY_EN
    logic          parity_bit;
`endif

    logic in_ram, hit_led, hit_tx, hit_clr;
    logic bit_end, pop, push, drop, going_idle, busy_next;

    assign in_ram  = mem_we && (mem_addr < 32'(RAM_WORDS));
    assign hit_led = mem_we && (mem_addr == MMIO_BASE);
    assign hit_tx  = mem_we && (mem_addr == MMIO_BASE + 32'd1);
    assign hit_clr = mem_we && (mem_addr == MMIO_BASE + 32'd2);

    // Pop only from a queue that was already non-empty before this edge, so a push
    // into an empty queue is never consumed in the same cycle.
    assign bit_end    = (clk_cnt == BIT_LAST);
    assign pop        = (count != '0) && ((state == S_IDLE) || (state == S_STOP && bit_end));
    assign push       = hit_tx && ((count != FIFO_FULL) || pop);
    assign drop       = hit_tx && !push;
    assign going_idle = (state == S_STOP) && bit_end && (count == '0);

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + 1'b1;
        else if (pop && !push)
            count_next = count - 1'b1;
    end

    assign busy_next = (count_next != '0) || pop || ((state != S_IDLE) && !going_idle);

    // NOTE: storage arrays carry no reset; only the control state around them is reset.
    always_ff @(posedge clk) begin
        if (in_ram)
            ram[mem_addr[AW-1:0]] <= mem_data;
        if (push)
            fifo[wr_ptr] <= mem_data[7:0];
    end

    // NOTE: sequential state uses non-blocking assignments so the read below sees the pre-edge word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            dbg_rdata <= '0;
        else
            dbg_rdata <= (dbg_addr < 32'(RAM_WORDS)) ? ram[dbg_addr[AW-1:0]] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led     <= '0;
            ovf     <= 1'b0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            tx_busy <= 1'b0;
            state   <= S_IDLE;
            clk_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            uart_tx <= 1'b1;
`ifdef DMEM_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            if (hit_led)
                led <= mem_data[7:0];
            if (drop)
                ovf <= 1'b1;
            else if (hit_clr)
                ovf <= 1'b0;

            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                shreg  <= fifo[rd_ptr];
`ifdef DMEM_TX_PARITY_EN
                parity_bit <= ^fifo[rd_ptr];
`endif
            end
            count   <= count_next;
            tx_busy <= busy_next;

            // uart_tx is loaded with the level of the bit being entered.
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        state   <= S_START;
                        clk_cnt <= '0;
                        uart_tx <= 1'b0;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        state   <= S_DATA;
                        clk_cnt <= '0;
                        bit_cnt <= '0;
                        uart_tx <= shreg[0];
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        shreg   <= {1'b0, shreg[7:1]};
                        if (bit_cnt == 3'd7) begin
`ifdef DMEM_TX_PARITY_EN
                            state   <= S_PARITY;
                            uart_tx <= parity_bit;
`else
                            state   <= S_STOP;
                            uart_tx <= 1'b1;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            uart_tx <= shreg[1];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
`ifdef DMEM_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        state   <= S_STOP;
                        clk_cnt <= '0;
                        uart_tx <= 1'b1;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (bit_end) begin
                        clk_cnt <= '0;
                        if (pop) begin
                            state   <= S_START;
                            uart_tx <= 1'b0;
                        end else begin
                            state   <= S_IDLE;
                            uart_tx <= 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    uart_tx <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: stimulus pushes expected debug words and UART bytes,
// independent monitors decode dbg_rdata and the serial line and compare.
module tb_dmem_responder;

    localparam logic [31:0] MMIO_BASE = 32'h0000_1000;
    localparam int CPB = 4;
`ifdef DMEM_TX_PARITY_EN
    localparam int FRAME = 11 * CPB;
`else
    localparam int FRAME = 10 * CPB;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] mem_addr, mem_data, dbg_addr;
    logic        mem_we;
    logic [31:0] dbg_rdata;
    logic [7:0]  led;
    logic        uart_tx, tx_busy, ovf;

    dmem_responder #(
        .RAM_WORDS(256), .MMIO_BASE(MMIO_BASE), .FIFO_DEPTH(4), .CLKS_PER_BIT(CPB)
    ) dut (
        .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
        .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata), .led(led), .uart_tx(uart_tx),
        .tx_busy(tx_busy), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic [31:0] dbg_q[$];
    logic [7:0]  tx_q[$];
    int          start_cyc[$];
    logic        rd_req = 1'b0;
    logic        rd_stage = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Debug-read monitor: a request captured on one edge is compared at the following negedge.
    always @(posedge clk) rd_stage <= rd_req;
    always @(negedge clk) begin
        if (rd_stage) begin
            check("dbg_expected_pending", 32'(dbg_q.size() != 0), 1);
            if (dbg_q.size() != 0)
                check("dbg_rdata", dbg_rdata, dbg_q.pop_front());
        end
    end

    task automatic wait_neg(input int n, output bit aborted);
        aborted = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (rst) begin
                aborted = 1'b1;
                return;
            end
        end
    endtask

    // UART monitor: detects a falling edge, samples each bit near its centre.
    initial begin : uart_mon
        bit prev;
        bit ab;
        logic [7:0] b;
        logic [7:0] exp_b;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev = 1'b1;
            end else if (prev && !uart_tx) begin
                start_cyc.push_back(cyc);
                b = '0;
                wait_neg(CPB / 2, ab);
                if (!ab) begin
                    check("uart_start_bit", 32'(uart_tx), 0);
                    check("tx_busy_in_frame", 32'(tx_busy), 1);
                end
                for (int i = 0; i < 8 && !ab; i++) begin
                    wait_neg(CPB, ab);
                    if (!ab) begin
                        b[i] = uart_tx;
                        check("tx_busy_in_frame", 32'(tx_busy), 1);
                    end
                end
`ifdef DMEM_TX_PARITY_EN
                if (!ab) wait_neg(CPB, ab);
                if (!ab) check("uart_parity_bit", 32'(uart_tx), 32'(^b));
`endif
                if (!ab) wait_neg(CPB, ab);
                if (!ab) begin
                    check("uart_stop_bit", 32'(uart_tx), 1);
                    check("tx_busy_in_frame", 32'(tx_busy), 1);
                    check("uart_frame_expected", 32'(tx_q.size() != 0), 1);
                    if (tx_q.size() != 0) begin
                        exp_b = tx_q.pop_front();
                        check("uart_byte", 32'(b), 32'(exp_b));
                    end
                end
                prev = 1'b1;
            end else begin
                prev = uart_tx;
            end
        end
    end

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        mem_addr = a;
        mem_data = d;
        mem_we   = 1'b1;
        @(negedge clk);
        mem_we   = 1'b0;
    endtask

    task automatic dbg_read(input logic [31:0] a, input logic [31:0] exp);
        dbg_addr = a;
        rd_req   = 1'b1;
        dbg_q.push_back(exp);
        @(negedge clk);
        rd_req   = 1'b0;
    endtask

    task automatic tx_push(input logic [7:0] b, input bit expect_sent);
        if (expect_sent) tx_q.push_back(b);
        store(MMIO_BASE + 32'd1, {24'hABCDEF, b});
    endtask

    task automatic drain();
        int i;
        i = 0;
        while ((tx_q.size() != 0 || tx_busy) && i < 3000) begin
            @(negedge clk);
            i++;
        end
        check("tx_drain_in_time", 32'(i < 3000), 1);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int p;
        int n;
        rst = 1'b1;
        mem_addr = '0; mem_data = '0; mem_we = 1'b0; dbg_addr = '0;
        repeat (3) @(negedge clk);
        check("reset_led", 32'(led), 0);
        check("reset_uart_tx", 32'(uart_tx), 1);
        check("reset_tx_busy", 32'(tx_busy), 0);
        check("reset_ovf", 32'(ovf), 0);
        check("reset_dbg_rdata", dbg_rdata, 0);
        rst = 1'b0;
        @(negedge clk);

        // Store then read back on the next cycle.
        store(32'd5, 32'hDEADBEEF);
        dbg_read(32'd5, 32'hDEADBEEF);

        // Read-first: same-cycle store and read of one address returns the old word.
        store(32'd7, 32'h0);
        mem_addr = 32'd7; mem_data = 32'h1; mem_we = 1'b1;
        dbg_addr = 32'd7; rd_req = 1'b1; dbg_q.push_back(32'h0);
        @(negedge clk);
        mem_we = 1'b0; rd_req = 1'b0;
        dbg_read(32'd7, 32'h1);

        // Out-of-range stores and reads must not alias into the RAM.
        store(32'd44, 32'hCAFE_F00D);
        store(MMIO_BASE, 32'h0000_01A5);
        check("led_write", 32'(led), 32'hA5);
        store(32'd300, 32'h1234_5678);
        check("led_after_oob", 32'(led), 32'hA5);
        check("ovf_after_oob", 32'(ovf), 0);
        dbg_read(32'd300, 32'h0);
        dbg_read(32'd44, 32'hCAFE_F00D);
        dbg_read(32'd5, 32'hDEADBEEF);

        // Single frame: 0x55.
        start_cyc.delete();
        p = cyc;
        tx_push(8'h55, 1'b1);
        check("tx_busy_after_push", 32'(tx_busy), 1);
        drain();
        check("single_frame_count", 32'(start_cyc.size()), 1);
        check("single_frame_start", 32'(start_cyc.size() > 0 ? start_cyc[0] : -1), 32'(p + 2));
        check("tx_busy_idle", 32'(tx_busy), 0);

        // Six back-to-back pushes into a 4-deep queue: first pops after one cycle, sixth dropped.
        start_cyc.delete();
        p = cyc;
        tx_push(8'h11, 1'b1);
        tx_push(8'h22, 1'b1);
        tx_push(8'h07, 1'b1);
        tx_push(8'h80, 1'b1);
        tx_push(8'hFF, 1'b1);
        tx_push(8'h66, 1'b0);
        check("ovf_set_on_drop", 32'(ovf), 1);
        store(MMIO_BASE + 32'd3, 32'h0);
        check("ovf_sticky", 32'(ovf), 1);
        drain();
        check("burst_frame_count", 32'(start_cyc.size()), 5);
        check("burst_first_start", 32'(start_cyc.size() > 0 ? start_cyc[0] : -1), 32'(p + 2));
        for (int k = 1; k < start_cyc.size(); k++)
            check("frames_contiguous", 32'(start_cyc[k] - start_cyc[k-1]), 32'(FRAME));
        store(MMIO_BASE + 32'd2, 32'hFFFF_FFFF);
        check("ovf_cleared", 32'(ovf), 0);

        // Asynchronous reset in the middle of the data bits of an all-zero byte.
        store(MMIO_BASE, 32'h3C);
        tx_push(8'h00, 1'b0);
        tx_push(8'h5A, 1'b0);
        repeat (8) @(negedge clk);
        check("pre_reset_line_low", 32'(uart_tx), 0);
        check("pre_reset_busy", 32'(tx_busy), 1);
        #2 rst = 1'b1;
        #1;
        check("async_reset_uart_tx", 32'(uart_tx), 1);
        check("async_reset_tx_busy", 32'(tx_busy), 0);
        check("async_reset_led", 32'(led), 0);
        n = start_cyc.size();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        check("no_frame_after_reset", 32'(start_cyc.size()), 32'(n));
        check("idle_line_after_reset", 32'(uart_tx), 1);
        check("idle_busy_after_reset", 32'(tx_busy), 0);
        check("dbg_queue_empty", 32'(dbg_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
